mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU controller's bus strobes: sel, rd, wr, data_e.
- Holds a 2^AWIDTH x DWIDTH RAM.
- Selects the address from the PC (sel=1) or the IR operand field (sel=0), returns read data to the instruction register and accumulator path, and commits accumulator stores.
- Supports programmable wait states, reported through a ready flag for the phase sequencer, and a side-band program-load port for bench and boot preload.

Parameters:
AWIDTH, 5, address width; memory depth is 2^AWIDTH words
DWIDTH, 8, data width
WAIT_STATES, 0, extra cycles per access; legal range 0..3

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous active-high reset
sel  in  1  address select: 1 = pc_addr, 0 = ir_addr
rd  in  1  read strobe, level; may be held for several cycles
wr  in  1  write strobe
data_e  in  1  data-bus drive enable from the controller
pc_addr  in  AWIDTH  program counter address
ir_addr  in  AWIDTH  instruction operand address
ac_out  in  DWIDTH  accumulator value to store
prog_we  in  1  preload write enable
prog_addr  in  AWIDTH  preload address
prog_data  in  DWIDTH  preload data
data_out  out  DWIDTH  registered read data; holds the last completed read
ready  out  1  1 = idle or access complete; 0 = wait states pending
err  out  1  sticky protocol-error flag

Behaviour:
- Address: addr = sel ? pc_addr : ir_addr, combinational.
- Edge detect: rd_q and wr_q are the strobes registered one cycle earlier; rd_rise = rd & ~rd_q, wr_rise = wr & ~wr_q.
- Reset: state=IDLE, ready=1, data_out=0, err=0, rd_q=0, wr_q=0, wait counter=0.
- Reset does not clear RAM contents.
- FSM states: IDLE and BUSY.
- IDLE, wr_rise & data_e at edge k:
  - mem[addr] <= ac_out, committed at edge k.
  - WAIT_STATES=0: stay IDLE, ready stays 1.
  - Otherwise: state=BUSY, cnt=WAIT_STATES, ready=0.
- IDLE, wr_rise & ~data_e: no write, err <= 1.
- IDLE, rd_rise at edge k:
  - Address is latched into lat_addr.
  - WAIT_STATES=0: data_out <= mem[addr] at edge k, ready stays 1.
  - Otherwise: state=BUSY, cnt=WAIT_STATES, ready=0.
- IDLE, rd_rise & wr_rise in the same cycle: the write is performed as above, the read is dropped, err <= 1.
- Held rd: while rd stays high with no new rising edge, no new access starts and data_out holds. Address changes during a held rd are not re-read.
- BUSY: cnt decrements each edge. On the edge where cnt==1:
  - For a read, data_out <= mem[lat_addr].
  - ready <= 1, state returns to IDLE.
  - ready is therefore low for exactly WAIT_STATES cycles.
- Request while BUSY: any rd_rise or wr_rise is ignored (no access, no write) and err <= 1.
- err: sticky; cleared only by rst.
- Preload:
  - prog_we=1 writes mem[prog_addr] <= prog_data in any state.
  - If a bus write lands on the same address in the same cycle, the preload wins and the bus write is lost. No error is flagged.
  - prog_we does not affect ready, data_out or the FSM.
- Read-during-write to the same address in the same cycle: the read returns the old contents (read-before-write).
- Reset mid-BUSY: the pending read is abandoned and data_out=0. A write already committed at its request edge remains in RAM.
- Address wrap: addresses are modulo 2^AWIDTH. There is no out-of-range case.
- Controller compatibility:
  - rd asserted in phases 1-3 with sel=1 gives one instruction fetch per instruction.
  - A store (data_e in phases 6-7, wr in phase 7) gives exactly one write.

Test Plan:
- Preload mem[3]=8'hA5; rst; sel=1, pc_addr=3, rd high for 3 cycles (WAIT_STATES=0) -> data_out=8'hA5 one edge after rd rises, ready stays 1, exactly one access.
- sel=0, ir_addr=5'h1F, ac_out=8'h3C, data_e high for 2 cycles, wr high on the 2nd cycle -> mem[31]=8'h3C; a subsequent read of ir_addr=31 returns 8'h3C; err=0.
- WAIT_STATES=2, read of an address holding 8'h11 -> ready low for exactly 2 cycles, data_out=8'h11 on the edge ready returns to 1; rd_rise while BUSY -> ignored, err=1.
- wr pulse with data_e=0 to address 4 holding 8'h77 -> mem[4] stays 8'h77, err=1; err stays 1 until rst, then returns to 0.
- rd and wr rising together, addr=7, ac_out=8'h5A, mem[7]=8'h00 -> mem[7]=8'h5A, data_out unchanged, err=1.
- WAIT_STATES=3, rst asserted in the 2nd BUSY cycle of a read -> ready=1, data_out=0, state IDLE next edge; preloaded RAM contents are intact after reset.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU bus strobes: edge-triggered reads/writes with
// optional wait states, a sticky protocol-error flag and a side-band preload port.
module mem_bus_responder #(
   parameter int AWIDTH      = 5,
   parameter int DWIDTH      = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              rd,
   input  logic              wr,
   input  logic              data_e,
   input  logic [AWIDTH-1:0] pc_addr,
   input  logic [AWIDTH-1:0] ir_addr,
   input  logic [DWIDTH-1:0] ac_out,
   input  logic              prog_we,
   input  logic [AWIDTH-1:0] prog_addr,
   input  logic [DWIDTH-1:0] prog_data,
   output logic [DWIDTH-1:0] data_out,
   output logic              ready,
   output logic              err
);

   localparam logic [1:0] C_WS = 2'(WAIT_STATES);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   logic [DWIDTH-1:0] r_mem [2**AWIDTH];

   state_t            r_state;
   state_t            w_state_next;
   logic [1:0]        r_cnt;
   logic [1:0]        w_cnt_next;
   logic              r_ready;
   logic              w_ready_next;
   logic              r_err;
   logic              w_err_next;
   logic              r_rd_q;
   logic              r_wr_q;
   logic [AWIDTH-1:0] r_lat_addr;
   logic [AWIDTH-1:0] w_lat_addr_next;
   logic              r_lat_rd;
   logic              w_lat_rd_next;
   logic [DWIDTH-1:0] r_data_out;

   logic [AWIDTH-1:0] w_addr;
   logic              w_rd_rise;
   logic              w_wr_rise;
   logic              w_bus_we;
   logic              w_start;
   logic              w_load;
   logic [AWIDTH-1:0] w_load_addr;

   assign w_addr    = sel ? pc_addr : ir_addr;
   assign w_rd_rise = rd & ~r_rd_q;
   assign w_wr_rise = wr & ~r_wr_q;

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_ready_next    = r_ready;
      w_err_next      = r_err;
      w_lat_addr_next = r_lat_addr;
      w_lat_rd_next   = r_lat_rd;
      w_bus_we        = 1'b0;
      w_start         = 1'b0;
      w_load          = 1'b0;
      w_load_addr     = w_addr;
      case (r_state)
         S_IDLE: begin
            // A simultaneous read and write keeps the write and drops the read.
            if (w_wr_rise) begin
               if (data_e) w_bus_we = 1'b1;
               else        w_err_next = 1'b1;
               if (w_rd_rise) w_err_next = 1'b1;
            end
            w_start = w_bus_we | (w_rd_rise & ~w_wr_rise);
            if (w_start) begin
               if (C_WS == 2'd0) begin
                  w_load = w_rd_rise & ~w_wr_rise;
               end else begin
                  w_state_next    = S_BUSY;
                  w_cnt_next      = C_WS;
                  w_ready_next    = 1'b0;
                  w_lat_addr_next = w_addr;
                  w_lat_rd_next   = w_rd_rise & ~w_wr_rise;
               end
            end
         end
         S_BUSY: begin
            if (w_rd_rise | w_wr_rise) w_err_next = 1'b1;
            w_cnt_next = 2'(r_cnt - 2'd1);
            if (r_cnt == 2'd1) begin
               w_state_next = S_IDLE;
               w_ready_next = 1'b1;
               w_load       = r_lat_rd;
               w_load_addr  = r_lat_addr;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= 2'd0;
         r_ready    <= 1'b1;
         r_err      <= 1'b0;
         r_rd_q     <= 1'b0;
         r_wr_q     <= 1'b0;
         r_lat_addr <= '0;
         r_lat_rd   <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_ready    <= w_ready_next;
         r_err      <= w_err_next;
         r_rd_q     <= rd;
         r_wr_q     <= wr;
         r_lat_addr <= w_lat_addr_next;
         r_lat_rd   <= w_lat_rd_next;
         if (w_load) r_data_out <= r_mem[w_load_addr];
      end
   end

   // Preload is written last so it overrides a bus write to the same word.
   always_ff @(posedge clk) begin
      if (w_bus_we && !rst) r_mem[w_addr] <= ac_out;
      if (prog_we)          r_mem[prog_addr] <= prog_data;
   end

   assign data_out = r_data_out;
   assign ready    = r_ready;
   assign err      = r_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Drives three responders (0, 2 and 3 wait states) with shared stimulus and checks
// every cycle's outputs against a cycle-numbered reference model via a scoreboard.
module tb_mem_bus_responder;

   localparam int AW = 5;
   localparam int DW = 8;
   localparam int NI = 3;
   localparam int WS_T [NI] = '{0, 2, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, sel, rd, wr, data_e, prog_we;
   logic [AW-1:0] pc_addr, ir_addr, prog_addr;
   logic [DW-1:0] ac_out, prog_data;
   logic [DW-1:0] dout_w  [NI];
   logic          ready_w [NI];
   logic          err_w   [NI];

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         mem_bus_responder #(
            .AWIDTH(AW), .DWIDTH(DW), .WAIT_STATES(WS_T[gi])
         ) u_dut (
            .clk(clk), .rst(rst), .sel(sel), .rd(rd), .wr(wr), .data_e(data_e),
            .pc_addr(pc_addr), .ir_addr(ir_addr), .ac_out(ac_out),
            .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
            .data_out(dout_w[gi]), .ready(ready_w[gi]), .err(err_w[gi])
         );
      end
   endgenerate

   typedef struct {
      int                      cyc;
      logic [NI-1:0][DW-1:0]   dout;
      logic [NI-1:0]           ready;
      logic [NI-1:0]           err;
   } exp_t;

   exp_t sb_q [$];
   int   checks   = 0;
   int   failures = 0;
   int   n_edge   = 1;
   int   mon_cyc  = 0;
   bit   stim_done = 1'b0;

   // Reference model: an access started at edge s finishes at edge s+WS.
   logic [DW-1:0] m_mem  [NI][32];
   logic [DW-1:0] m_dout [NI];
   bit            m_err  [NI];
   bit            m_rdq  [NI];
   bit            m_wrq  [NI];
   bit            m_pread[NI];
   logic [AW-1:0] m_paddr[NI];
   int            m_done [NI];

   task automatic model_and_push();
      exp_t e;
      e.cyc = n_edge;
      for (int i = 0; i < NI; i++) begin
         logic [AW-1:0] a;
         bit rr, wrr, bus_we, is_rd;
         a      = sel ? pc_addr : ir_addr;
         rr     = rd && !m_rdq[i];
         wrr    = wr && !m_wrq[i];
         bus_we = 1'b0;
         if (rst) begin
            m_dout[i] = '0;
            m_err[i]  = 1'b0;
            m_done[i] = 0;
         end else if (n_edge <= m_done[i]) begin
            if (rr || wrr) m_err[i] = 1'b1;
            if (n_edge == m_done[i] && m_pread[i]) m_dout[i] = m_mem[i][m_paddr[i]];
         end else begin
            is_rd = rr && !wrr;
            if (wrr && !data_e) m_err[i] = 1'b1;
            if (rr && wrr)      m_err[i] = 1'b1;
            bus_we = wrr && data_e;
            if (bus_we || is_rd) begin
               if (WS_T[i] == 0) begin
                  if (is_rd) m_dout[i] = m_mem[i][a];
               end else begin
                  m_done[i]  = n_edge + WS_T[i];
                  m_pread[i] = is_rd;
                  m_paddr[i] = a;
               end
            end
         end
         if (bus_we)  m_mem[i][a] = ac_out;
         if (prog_we) m_mem[i][prog_addr] = prog_data;
         m_rdq[i] = rst ? 1'b0 : rd;
         m_wrq[i] = rst ? 1'b0 : wr;
         e.dout[i]  = m_dout[i];
         e.ready[i] = (m_done[i] <= n_edge);
         e.err[i]   = m_err[i];
      end
      sb_q.push_back(e);
   endtask

   task automatic tick();
      model_and_push();
      @(posedge clk);
      #1;
      n_edge++;
   endtask

   task automatic idle(input int n);
      rst = 1'b0; rd = 1'b0; wr = 1'b0; data_e = 1'b0; prog_we = 1'b0;
      repeat (n) tick();
   endtask

   // Monitor: compare each edge's outputs on the following falling edge.
   initial begin
      forever begin
         @(posedge clk);
         mon_cyc++;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= mon_cyc) begin
            e = sb_q.pop_front();
            if (e.cyc != mon_cyc) begin
               checks++; failures++;
               $display("FAIL stale_entry cyc=%0d monitor_cyc=%0d", e.cyc, mon_cyc);
            end else begin
               for (int i = 0; i < NI; i++) begin
                  checks++;
                  if (dout_w[i] !== e.dout[i]) begin
                     failures++;
                     $display("FAIL data_out ws=%0d cyc=%0d got=%02h exp=%02h", WS_T[i], mon_cyc, dout_w[i], e.dout[i]);
                  end
                  checks++;
                  if (ready_w[i] !== e.ready[i]) begin
                     failures++;
                     $display("FAIL ready ws=%0d cyc=%0d got=%0b exp=%0b", WS_T[i], mon_cyc, ready_w[i], e.ready[i]);
                  end
                  checks++;
                  if (err_w[i] !== e.err[i]) begin
                     failures++;
                     $display("FAIL err ws=%0d cyc=%0d got=%0b exp=%0b", WS_T[i], mon_cyc, err_w[i], e.err[i]);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; data_e = 1'b0; prog_we = 1'b0;
      pc_addr = '0; ir_addr = '0; ac_out = '0; prog_addr = '0; prog_data = '0;
      for (int i = 0; i < NI; i++) begin
         m_dout[i] = '0; m_err[i] = 1'b0; m_rdq[i] = 1'b0; m_wrq[i] = 1'b0;
         m_pread[i] = 1'b0; m_paddr[i] = '0; m_done[i] = 0;
      end

      // Preload every word under reset, with known values at 3, 4, 7, 9.
      for (int a = 0; a < 32; a++) begin
         rst = 1'b1; prog_we = 1'b1; prog_addr = AW'(a);
         case (a)
            3:       prog_data = 8'hA5;
            4:       prog_data = 8'h77;
            7:       prog_data = 8'h00;
            9:       prog_data = 8'h11;
            default: prog_data = DW'($urandom);
         endcase
         tick();
      end
      idle(2);

      // Fetch held for three cycles: one access only.
      sel = 1'b1; pc_addr = 5'd3; rd = 1'b1;
      repeat (3) tick();
      idle(4);

      // Store to 31 with data_e leading wr, then read it back.
      sel = 1'b0; ir_addr = 5'h1F; ac_out = 8'h3C; data_e = 1'b1;
      tick();
      wr = 1'b1; tick();
      idle(4);
      sel = 1'b0; ir_addr = 5'h1F; rd = 1'b1; tick();
      idle(4);

      // Read of 0x11, then a second rising edge while still busy.
      ir_addr = 5'd9; rd = 1'b1; tick();
      rd = 1'b0; tick();
      rd = 1'b1; tick();
      idle(5);

      // Write without data_e; err must persist until reset.
      ir_addr = 5'd4; ac_out = 8'hEE; wr = 1'b1; tick();
      idle(3);
      rst = 1'b1; tick();
      idle(1);
      ir_addr = 5'd4; rd = 1'b1; tick();
      idle(4);

      // Read and write rising together at 7.
      ir_addr = 5'd7; ac_out = 8'h5A; data_e = 1'b1; rd = 1'b1; wr = 1'b1; tick();
      idle(4);
      ir_addr = 5'd7; rd = 1'b1; tick();
      idle(4);

      // Reset during the second busy cycle of a read.
      sel = 1'b1; pc_addr = 5'd3; rd = 1'b1; tick();
      tick();
      rst = 1'b1; tick();
      idle(1);
      pc_addr = 5'd3; rd = 1'b1; tick();
      idle(4);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 149) == 0);
         prog_we   = ($urandom_range(0, 9) == 0);
         prog_addr = AW'($urandom);
         prog_data = DW'($urandom);
         if ($urandom_range(0, 3) == 0) rd = ~rd;
         wr        = ($urandom_range(0, 7) == 0);
         data_e    = ($urandom_range(0, 7) != 0);
         sel       = 1'($urandom);
         pc_addr   = AW'($urandom);
         ir_addr   = AW'($urandom);
         ac_out    = DW'($urandom);
         tick();
      end
      idle(6);
      stim_done = 1'b1;
   end

   // Completion check with a hard time bound.
   initial begin
      fork
         begin
            wait (stim_done);
            @(negedge clk);
            @(negedge clk);
         end
         begin
            #1000000;
            checks++; failures++;
            $display("FAIL timeout stimulus did not complete");
         end
      join_any
      disable fork;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
